bus_arbiter_ctrl: RTL



---
 rtl/bus_arbiter_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_ctrl.sv
// ----------------------------------------------------------------------------
// bus_arbiter_ctrl
//
// Registered, transaction-aware arbiter for the shared system bus.
// Masters: m0 = ex, m1 = ifu, m2 = JTAG. A grant is held until the slave
// acknowledges or the master drops its request; a locked master keeps the bus
// across back-to-back accesses. The ifu gets starvation protection, and the
// pipeline hold flag is derived here.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   req_i[2:0]     per-master request, bit n = master n
//   lock_i[2:0]    per-master lock: keep the grant after ack_i
//   ack_i          slave completes the current granted access this cycle
//   grant_o[1:0]   granted master index (0, 1 or 2); parks at 1 when idle
//   grant_valid_o  grant_o refers to an active transaction
//   hold_flag_o    pipeline hold request (combinational)
//   timeout_o      one-cycle pulse on watchdog release
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : BUSY watchdog releases the bus after TIMEOUT_CYCLES cycles
//               without ack_i; the offending master must drop and re-raise
//               its request before it is eligible again.
//   Undefined : no watchdog, timeout_o tied to 0.
// ----------------------------------------------------------------------------
module bus_arbiter_ctrl #(
    parameter int STARVE_MAX     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic [2:0] lock_i,
    input  logic       ack_i,
    output logic [1:0] grant_o,
    output logic       grant_valid_o,
    output logic       hold_flag_o,
    output logic       timeout_o
);

    if ((2 ** CNT_W) <= STARVE_MAX || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("CNT_W too narrow for STARVE_MAX / TIMEOUT_CYCLES");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0]       PARK       = 2'd1;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [2:0]       eligible;
    logic [1:0]       winner;
    logic             any_elig;
    logic             cur_req, cur_lock;
    logic             busy_ifu;
    logic             starve_hit;

    // Fixed priority m0 > m2 > m1, unless the ifu starvation override fires.
    function automatic logic [1:0] arbitrate(input logic [2:0] req, input logic ifu_first);
        logic [1:0] w;
        if (ifu_first && req[1])
            w = 2'd1;
        else if (req[0])
            w = 2'd0;
        else if (req[2])
            w = 2'd2;
        else
            w = 2'd1;
        return w;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_q, wd_d;
    logic [2:0]       blocked_q, blocked_d, block_set;
    logic             timeout_q, timeout_d;

    // A master released by the watchdog stays ineligible until it drops req.
    assign eligible = req_i & ~blocked_q;
`else
    assign eligible = req_i;
`endif

    assign any_elig = |eligible;
    assign busy_ifu = (state_q == BUSY) && (cur_q == 2'd1);
    // The counter clears in any cycle ifu holds the grant, so the override
    // must not fire in that same cycle or ifu would win twice in a row.
    assign starve_hit = (starve_q == STARVE_LIM) && !busy_ifu;
    assign winner     = arbitrate(eligible, starve_hit);

    always_comb begin
        unique case (cur_q)
            2'd0: begin
                cur_req  = req_i[0];
                cur_lock = lock_i[0];
            end
            2'd2: begin
                cur_req  = req_i[2];
                cur_lock = lock_i[2];
            end
            default: begin
                cur_req  = req_i[1];
                cur_lock = lock_i[1];
            end
        endcase
    end

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= PARK;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            starve_q <= starve_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            blocked_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            blocked_q <= blocked_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    // ---------------- next-state logic ----------------
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
`ifdef ARB_TIMEOUT_EN
        block_set = 3'b000;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = BUSY;
                    cur_d   = winner;
                end
            end
            BUSY: begin
                if (!cur_req || (ack_i && !cur_lock)) begin
                    // Abort (also wins over a same-cycle ack) or unlocked ack:
                    // hand over without a bubble, or fall back to idle.
                    if (any_elig) begin
                        cur_d = winner;
                    end else begin
                        state_d = IDLE;
                        cur_d   = PARK;
                    end
                end else if (ack_i) begin
                    // Locked and still requesting: keep cur, no re-arbitration.
                    cur_d = cur_q;
`ifdef ARB_TIMEOUT_EN
                end else if (wd_q == WD_LIM) begin
                    state_d   = IDLE;
                    cur_d     = PARK;
                    timeout_d = 1'b1;
                    block_set = 3'b001 << cur_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cur_d   = PARK;
            end
        endcase

        if (!req_i[1] || busy_ifu)
            starve_d = '0;
        else if (starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
        else
            starve_d = starve_q;

`ifdef ARB_TIMEOUT_EN
        if (state_q == BUSY && state_d == BUSY && cur_d == cur_q && !ack_i)
            wd_d = wd_q + 1'b1;
        else
            wd_d = '0;
        blocked_d = req_i & (blocked_q | block_set);
`endif
    end

    // ---------------- outputs ----------------
    always_comb begin
        grant_o       = cur_q;
        grant_valid_o = (state_q == BUSY);
        // An ifu-only transaction never stalls the pipeline.
        hold_flag_o   = req_i[0] | req_i[2] | ((state_q == BUSY) && (cur_q != 2'd1));
`ifdef ARB_TIMEOUT_EN
        timeout_o     = timeout_q;
`else
        timeout_o     = 1'b0;
`endif
    end

endmodule
